comparator_reg: RTL and testbench
=================================

Name: comparator_reg

Overview:
- Registered magnitude comparator for two unsigned WIDTH-bit operands A and B.
- Produces three mutually exclusive one-hot flags: gt (A>B), eq (A==B), lt (A<B).
- Used as a small datapath helper: sample operands with a valid strobe, then read the result a fixed number of cycles later.
- Default WIDTH=2 covers the 4-input-bit / 3-output-bit case: A={x1,x0}, B={x3,x2}, z0=gt, z1=eq, z2=lt.

Parameters:
- WIDTH, 2, operand width in bits (legal range 1..32).
- LATENCY, 1, number of register stages from input sample to result (legal range 1..4).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands are sampled on a rising edge when this is high.
- a  input  WIDTH  operand A; for WIDTH=2, a[1]=x1 and a[0]=x0.
- b  input  WIDTH  operand B; for WIDTH=2, b[1]=x3 and b[0]=x2.
- out_valid  output  1  high for one cycle when gt/eq/lt carry a fresh result.
- gt  output  1  A>B (z0).
- eq  output  1  A==B (z1).
- lt  output  1  A<B (z2).

Behaviour:
- Reset, when rst is high at a rising edge:
  - every pipeline stage clears, and out_valid=0, gt=0, eq=0, lt=0 on the next cycle;
  - rst overrides in_valid in the same cycle;
  - rst asserted mid-pipeline discards all in-flight results, so no out_valid pulse is produced for them.
- Comparison:
  - combinational core computes the flags for the current a/b;
  - default build treats operands as unsigned;
  - exactly one of gt/eq/lt is 1 whenever out_valid=1.
- Latency and valid behaviour:
  - a sample taken at edge N appears on the outputs after edge N+LATENCY-1, i.e. visible in the cycle following that edge;
  - out_valid follows in_valid delayed by LATENCY;
  - back-to-back in_valid on every cycle is supported: full throughput, one result per cycle, in order.
- When in_valid=0 the stage keeps its previous flag values and clears its valid bit. The output flags therefore hold the last result while out_valid=0; after reset they are all 0 until the first result.
- There is no backpressure: results cannot be stalled.
- Width: a and b are compared at full WIDTH, with no truncation or extension.
- Boundary cases:
  - A=0, B=0 gives eq;
  - A=all-ones, B=0 gives gt;
  - A=0, B=all-ones gives lt.

Optional Feature:
- Macro: COMPARATOR_SIGNED_EN.
- When defined: a and b are interpreted as two's-complement signed values. Example for WIDTH=2: A=2'b11 (-1) vs B=2'b01 (+1) gives lt.
- When undefined: unsigned comparison; the same example gives gt.
- Ports, latency and reset behaviour are identical in both builds.

Decomposition:
- Package comparator_pkg holds:
  - typedef cmp_res_t, a 3-bit one-hot struct {lt, eq, gt};
  - constants CMP_GT=3'b001, CMP_EQ=3'b010, CMP_LT=3'b100 (bit i = z_i);
  - constant CMP_NONE=3'b000, the reset value.
- Sub-module comparator_core: purely combinational, WIDTH parameter, inputs a/b, output cmp_res_t. It is the only place the signed/unsigned macro is evaluated.
- The top level owns the LATENCY-deep pipeline of {valid, cmp_res_t} registers.

Test Plan:
- Reset: hold rst=1 with in_valid=1, a=3, b=0 for 3 cycles -> out_valid=0 and gt=eq=lt=0 throughout. Release rst -> outputs stay 0 until the first valid sample emerges.
- Exhaustive sweep, WIDTH=2, LATENCY=1: drive i=0..15 with {b,a}=i and in_valid=1 on every cycle -> one cycle later, flags are one-hot and correct for all 16 pairs (e.g. i=6: a=2, b=1 -> gt; i=5: a=1, b=1 -> eq; i=4: a=0, b=1 -> lt). out_valid stays high continuously.
- Hold and valid gap: sample a=1, b=2 (lt), then in_valid=0 for 3 cycles with a=3, b=0 on the pins -> lt stays 1 and out_valid=0 during the gap.
- Latency: LATENCY=3, single in_valid pulse with a=2, b=2 -> exactly one out_valid pulse, 3 edges later, with eq=1.
- Reset mid-pipeline: LATENCY=3, issue 2 samples, assert rst one cycle later -> no out_valid pulse appears and flags are 0.
- Signed build (COMPARATOR_SIGNED_EN): a=2'b10 (-2), b=2'b01 (+1) -> lt. The same stimulus in the unsigned build -> gt.

Source files
------------

// File: rtl/comparator_pkg.sv
// Shared types and constants for the registered magnitude comparator.
package comparator_pkg;

  localparam int unsigned CMP_RES_W = 3;

  // One-hot result; bit i corresponds to output z_i (z0=gt, z1=eq, z2=lt).
  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_res_t;

  localparam cmp_res_t CMP_GT   = CMP_RES_W'(3'b001);
  localparam cmp_res_t CMP_EQ   = CMP_RES_W'(3'b010);
  localparam cmp_res_t CMP_LT   = CMP_RES_W'(3'b100);
  localparam cmp_res_t CMP_NONE = CMP_RES_W'(3'b000);

endpackage

// File: rtl/comparator_reg_if.sv
// Operand/result bundle for comparator_reg; master drives operands, slave returns flags.
interface comparator_reg_if #(
  parameter int unsigned WIDTH = 2
);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             gt;
  logic             eq;
  logic             lt;

  modport master (
    output in_valid, a, b,
    input  out_valid, gt, eq, lt
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, gt, eq, lt
  );

endinterface

// File: rtl/comparator_core.sv
// Combinational magnitude compare of a against b.
// Signed two's-complement compare when COMPARATOR_SIGNED_EN is defined, unsigned otherwise.
module comparator_core
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output cmp_res_t         res
);

  always_comb begin
    res = CMP_NONE;
`ifdef COMPARATOR_SIGNED_EN
    if ($signed(a) > $signed(b)) begin
      res = CMP_GT;
    end else if (a == b) begin
      res = CMP_EQ;
    end else begin
      res = CMP_LT;
    end
`else
    if (a > b) begin
      res = CMP_GT;
    end else if (a == b) begin
      res = CMP_EQ;
    end else begin
      res = CMP_LT;
    end
`endif
  end

endmodule

// File: rtl/comparator_reg.sv
// Registered comparator: LATENCY-deep {valid, result} pipeline behind comparator_core.
// Optional signed compare is selected by COMPARATOR_SIGNED_EN inside the core.
module comparator_reg
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH   = 2,
  parameter int unsigned LATENCY = 1
) (
  input logic             clk,
  input logic             rst,
  comparator_reg_if.slave bus
);

  cmp_res_t res_c;
  logic     valid_q [LATENCY];
  cmp_res_t res_q   [LATENCY];

  comparator_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a  (bus.a),
    .b  (bus.b),
    .res(res_c)
  );

  // Entry stage: flags only load on a valid sample so the last result is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q[0] <= 1'b0;
      res_q[0]   <= CMP_NONE;
    end else begin
      valid_q[0] <= bus.in_valid;
      if (bus.in_valid) begin
        res_q[0] <= res_c;
      end
    end
  end

  for (genvar i = 1; i < int'(LATENCY); i++) begin : g_stage
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q[i] <= 1'b0;
        res_q[i]   <= CMP_NONE;
      end else begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) begin
          res_q[i] <= res_q[i-1];
        end
      end
    end
  end

  assign bus.out_valid = valid_q[LATENCY-1];
  assign bus.gt        = res_q[LATENCY-1].gt;
  assign bus.eq        = res_q[LATENCY-1].eq;
  assign bus.lt        = res_q[LATENCY-1].lt;

endmodule

// File: tb/tb_comparator_reg.sv
// Self-checking bench for comparator_reg: three instances (W2/L1, W2/L3, W8/L2) against a delay-queue model.
module tb_comparator_reg;

  logic clk = 1'b0;
  logic rst1, rst3, rstw;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  comparator_reg_if #(.WIDTH(2)) if1 ();
  comparator_reg_if #(.WIDTH(2)) if3 ();
  comparator_reg_if #(.WIDTH(8)) ifw ();

  comparator_reg #(.WIDTH(2), .LATENCY(1)) dut1 (.clk(clk), .rst(rst1), .bus(if1));
  comparator_reg #(.WIDTH(2), .LATENCY(3)) dut3 (.clk(clk), .rst(rst3), .bus(if3));
  comparator_reg #(.WIDTH(8), .LATENCY(2)) dutw (.clk(clk), .rst(rstw), .bus(ifw));

  // Observed {out_valid, lt, eq, gt} per instance: 0=dut1, 1=dut3, 2=dutw.
  logic [3:0] obs [3];
  assign obs[0] = {if1.out_valid, if1.lt, if1.eq, if1.gt};
  assign obs[1] = {if3.out_valid, if3.lt, if3.eq, if3.gt};
  assign obs[2] = {ifw.out_valid, ifw.lt, ifw.eq, ifw.gt};

  // Model state: pending samples per instance, last delivered flags, expected outputs.
  logic [3:0]  q    [3][$];
  logic [2:0]  held [3];
  logic [3:0]  exp_o[3];
  int unsigned lat  [3] = '{1, 3, 2};

  // Reference compare from integer values; returns {lt, eq, gt}.
  function automatic logic [2:0] ref_cmp(input logic [7:0] a, input logic [7:0] b, input int w);
    int sa;
    int sb;
    sa = int'(a);
    sb = int'(b);
`ifdef COMPARATOR_SIGNED_EN
    if (a[w-1]) sa = sa - (1 << w);
    if (b[w-1]) sb = sb - (1 << w);
`else
    if (w < 1) sa = 0;
`endif
    if (sa > sb) return 3'b001;
    if (sa == sb) return 3'b010;
    return 3'b100;
  endfunction

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic cycle();
    logic [3:0] ent [3];
    logic       r   [3];
    logic [3:0] e;
    ent[0] = {if1.in_valid, ref_cmp(8'(if1.a), 8'(if1.b), 2)};
    ent[1] = {if3.in_valid, ref_cmp(8'(if3.a), 8'(if3.b), 2)};
    ent[2] = {ifw.in_valid, ref_cmp(ifw.a, ifw.b, 8)};
    r[0] = rst1;
    r[1] = rst3;
    r[2] = rstw;
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      if (r[d]) begin
        q[d].delete();
        held[d]  = 3'b000;
        exp_o[d] = 4'b0000;
      end else begin
        q[d].push_back(ent[d]);
        if (q[d].size() >= int'(lat[d])) begin
          e = q[d].pop_front();
          if (e[3]) held[d] = e[2:0];
          exp_o[d] = {e[3], held[d]};
        end else begin
          exp_o[d] = {1'b0, held[d]};
        end
      end
    end
    #1;
  endtask

  task automatic idle_all();
    if1.in_valid = 1'b0;
    if3.in_valid = 1'b0;
    ifw.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst3 = 1'b1; rstw = 1'b1;
    if1.in_valid = 1'b1; if1.a = 2'd3; if1.b = 2'd0;
    if3.in_valid = 1'b1; if3.a = 2'd3; if3.b = 2'd0;
    ifw.in_valid = 1'b1; ifw.a = 8'd3; ifw.b = 8'd0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs[d] !== 4'b0000) begin
          errors++;
          $display("FAIL reset_hold[%0d] cyc%0d: got %b expected 0000", d, k, obs[d]);
        end
      end
    end
    rst1 = 1'b0; rst3 = 1'b0; rstw = 1'b0;
    idle_all();
    for (int k = 0; k < 3; k++) begin
      cycle();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (obs[d] !== 4'b0000) begin
          errors++;
          $display("FAIL reset_release[%0d] cyc%0d: got %b expected 0000", d, k, obs[d]);
        end
      end
    end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      if1.in_valid = 1'b1;
      if1.a = v[1:0];
      if1.b = v[3:2];
      cycle();
      checks++;
      if (obs[0] !== exp_o[0] || obs[0][3] !== 1'b1) begin
        errors++;
        $display("FAIL sweep i=%0d: got %b expected %b", i, obs[0], exp_o[0]);
      end
    end
    idle_all();
  endtask

  task automatic test_boundary();
    logic [2:0] want [3];
    logic [1:0] av   [3];
    logic [1:0] bv   [3];
    av = '{2'd0, 2'd3, 2'd0};
    bv = '{2'd0, 2'd0, 2'd3};
`ifdef COMPARATOR_SIGNED_EN
    want = '{3'b010, 3'b100, 3'b001};
`else
    want = '{3'b010, 3'b001, 3'b100};
`endif
    for (int k = 0; k < 3; k++) begin
      if1.in_valid = 1'b1; if1.a = av[k]; if1.b = bv[k];
      cycle();
      checks++;
      if (obs[0] !== {1'b1, want[k]}) begin
        errors++;
        $display("FAIL boundary a=%0d b=%0d: got %b expected %b", av[k], bv[k], obs[0], {1'b1, want[k]});
      end
    end
    idle_all();
    cycle();
  endtask

  task automatic test_hold_gap();
    if1.in_valid = 1'b1; if1.a = 2'd1; if1.b = 2'd2;
    cycle();
    checks++;
    if (obs[0] !== 4'b1100) begin
      errors++;
      $display("FAIL gap_sample: got %b expected 1100", obs[0]);
    end
    if1.in_valid = 1'b0; if1.a = 2'd3; if1.b = 2'd0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (obs[0] !== 4'b0100) begin
        errors++;
        $display("FAIL gap_hold cyc%0d: got %b expected 0100", k, obs[0]);
      end
    end
  endtask

  task automatic test_signed();
    logic [2:0] want;
`ifdef COMPARATOR_SIGNED_EN
    want = 3'b100;
`else
    want = 3'b001;
`endif
    if1.in_valid = 1'b1; if1.a = 2'b10; if1.b = 2'b01;
    cycle();
    checks++;
    if (obs[0] !== {1'b1, want}) begin
      errors++;
      $display("FAIL signed_mode: got %b expected %b", obs[0], {1'b1, want});
    end
    idle_all();
    cycle();
  endtask

  task automatic test_latency();
    int pulses;
    int first;
    pulses = 0;
    first  = -1;
    if3.in_valid = 1'b1; if3.a = 2'd2; if3.b = 2'd2;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (k == 0) begin
        if3.in_valid = 1'b0; if3.a = 2'd0; if3.b = 2'd3;
      end
      checks++;
      if (obs[1] !== exp_o[1]) begin
        errors++;
        $display("FAIL latency cyc%0d: got %b expected %b", k, obs[1], exp_o[1]);
      end
      if (obs[1][3] === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (pulses != 1 || first != 2) begin
      errors++;
      $display("FAIL latency_pulse: got %0d pulses first at %0d, expected 1 at 2", pulses, first);
    end
    checks++;
    if (obs[1] !== 4'b0010) begin
      errors++;
      $display("FAIL latency_eq_held: got %b expected 0010", obs[1]);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    if3.in_valid = 1'b1; if3.a = 2'd3; if3.b = 2'd1;
    cycle();
    if3.a = 2'd0; if3.b = 2'd2;
    cycle();
    rst3 = 1'b1;
    if3.a = 2'd1; if3.b = 2'd1;
    cycle();
    rst3 = 1'b0;
    if3.in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (obs[1][3] === 1'b1) pulses++;
      checks++;
      if (obs[1] !== 4'b0000) begin
        errors++;
        $display("FAIL reset_mid cyc%0d: got %b expected 0000", k, obs[1]);
      end
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_mid_pulses: got %0d expected 0", pulses);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 24; k++) begin
      if3.in_valid = 1'b1;
      if3.a = 2'($urandom_range(0, 3));
      if3.b = 2'($urandom_range(0, 3));
      cycle();
      checks++;
      if (obs[1] !== exp_o[1]) begin
        errors++;
        $display("FAIL back_to_back cyc%0d: got %b expected %b", k, obs[1], exp_o[1]);
      end
    end
    idle_all();
    for (int k = 0; k < 4; k++) begin
      cycle();
      checks++;
      if (obs[1] !== exp_o[1]) begin
        errors++;
        $display("FAIL back_to_back_drain cyc%0d: got %b expected %b", k, obs[1], exp_o[1]);
      end
    end
  endtask

  task automatic test_random_wide();
    for (int k = 0; k < 300; k++) begin
      int sel;
      sel = int'($urandom_range(0, 7));
      ifw.in_valid = 1'($urandom_range(0, 3) != 0);
      case (sel)
        0:       begin ifw.a = 8'h00; ifw.b = 8'h00; end
        1:       begin ifw.a = 8'hff; ifw.b = 8'h00; end
        2:       begin ifw.a = 8'h00; ifw.b = 8'hff; end
        3:       begin ifw.a = 8'($urandom); ifw.b = ifw.a; end
        default: begin ifw.a = 8'($urandom); ifw.b = 8'($urandom); end
      endcase
      rstw = 1'($urandom_range(0, 49) == 0);
      cycle();
      checks++;
      if (obs[2] !== exp_o[2]) begin
        errors++;
        $display("FAIL random_wide cyc%0d: got %b expected %b", k, obs[2], exp_o[2]);
      end
      if (obs[2][3] === 1'b1 && !$onehot(obs[2][2:0])) begin
        errors++;
        $display("FAIL onehot_wide cyc%0d: got %b expected one-hot flags", k, obs[2]);
      end
    end
    rstw = 1'b0;
    idle_all();
  endtask

  initial begin
    rst1 = 1'b1; rst3 = 1'b1; rstw = 1'b1;
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0;
    if3.in_valid = 1'b0; if3.a = '0; if3.b = '0;
    ifw.in_valid = 1'b0; ifw.a = '0; ifw.b = '0;
    test_reset();
    test_sweep();
    test_boundary();
    test_hold_gap();
    test_signed();
    test_latency();
    test_reset_mid();
    test_back_to_back();
    test_random_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
